// File: rtl/cmd_streamer.sv
// cmd_streamer: scans the command memory and streams each entry's
// OLED acceleration bytes to the SPI transmitter, with a post-draw gap.
module cmd_streamer #(
  parameter int N_ENTRIES  = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [95:0]       rd_data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GAP_CYCLES > 0) ?
    $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, GAP, NEXT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [95:0]       hold;
  logic [3:0]        idx;
  logic [3:0]        nbytes;
  logic [GW-1:0]     gap_cnt;
  logic [3:0]        ld_len;
  logic              unused_hold;

  assign unused_hold = ^hold[95:93];

  function automatic logic [3:0] class_len(
    input logic [3:0] c
  );
    case (c)
      4'd1:    return 4'd5;
      4'd2:    return 4'd7;
      4'd3:    return 4'd8;
      4'd4:    return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  // Class 4 prepends the 0x26 prefix and the fill flag byte.
  function automatic logic [7:0] byte_at(
    input logic [92:0] w,
    input logic [3:0]  i
  );
    logic [87:0] sh;
    logic [3:0]  j;
    j = i;
    if (w[91:88] == 4'd4) begin
      if (i == 4'd0) return 8'h26;
      if (i == 4'd1) return {7'b0, w[92]};
      j = i - 4'd2;
    end
    sh = w[87:0] << {j, 3'b000};
    return sh[87:80];
  endfunction

  assign ld_len = class_len(rd_data[91:88]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      idx        <= '0;
      nbytes     <= '0;
      gap_cnt    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            state   <= FETCH;
            cnt     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          hold   <= rd_data;
          nbytes <= ld_len;
          idx    <= '0;
          if (ld_len == 4'd0) begin
            state <= NEXT;
          end else begin
            state      <= SEND;
            byte_valid <= 1'b1;
            byte_out   <= byte_at(rd_data[92:0], 4'd0);
          end
        end
        SEND: begin
          if (byte_ready) begin
            if (idx == nbytes - 4'd1) begin
              byte_valid <= 1'b0;
              gap_cnt    <= '0;
              state      <= (GAP_CYCLES == 0) ? NEXT : GAP;
            end else begin
              idx      <= idx + 4'd1;
              byte_out <= byte_at(hold[92:0], idx + 4'd1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= NEXT;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        NEXT: begin
          if (cnt == ADDR_W'(N_ENTRIES - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt     <= cnt + 1'b1;
            rd_addr <= cnt + 1'b1;
            rd_en   <= 1'b1;
            state   <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmd_streamer.md
Name: cmd_streamer

Overview:
Drains the compiled 8-entry command memory and emits each entry as a byte stream of OLED graphics-acceleration commands to the SPI byte transmitter. Sits between the command memory read port and the SPI master; one run is triggered by `start` after compilation completes. Per entry, the 4-bit command-class field selects how many bytes of the 96-bit word are sent. A programmable idle gap after each drawn command covers the panel's graphics execution time.

Parameters:
N_ENTRIES, 8, number of command memory entries scanned per run
ADDR_W, 3, command memory address width
GAP_CYCLES, 100, idle clk cycles inserted after the last byte of each non-skipped entry (0 allowed = no gap)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle run request; sampled only in IDLE
rd_en  out  1  command memory read strobe
rd_addr  out  ADDR_W  command memory read address
rd_data  in  96  command word; valid exactly one cycle after rd_en
byte_out  out  8  command byte to SPI master
byte_valid  out  1  byte_out is valid
byte_ready  in  1  SPI master accepts byte_out this cycle
busy  out  1  run in progress
done  out  1  one-cycle pulse when a run finishes

Behaviour:
- Reset values (async): rd_en=0, rd_addr=0, byte_out=0, byte_valid=0, busy=0, done=0; state=IDLE; entry counter=0.
- Command word fields:
  - [92] fill
  - [91:88] class
  - [87:80] opcode
  - [79:48] four coordinate bytes C0..C3, MSB first
  - [47:0] six payload bytes P0..P5, MSB first ([47:40]=P0).
- Class decode:
  - 1: opcode, C0..C3 (5 bytes).
  - 2: opcode, C0..C3, P0, P1 (7 bytes).
  - 3: opcode, C0..C3, P0..P2 (8 bytes).
  - 4: prefix 0x26 then fill byte (0x01 if fill=1 else 0x00), then opcode, C0..C3, P0..P5 (13 bytes).
  - 0, 5..15: entry skipped; no bytes, no gap.
- The opcode byte is taken from the word, never regenerated.
- States:
  - IDLE: busy=0. On start=1, go to FETCH with counter=0, busy=1.
  - FETCH: rd_en=1 for one cycle, rd_addr=counter. Go to LOAD.
  - LOAD: latch rd_data into a 96-bit holding register, decode class into a byte count. Skip goes to NEXT; otherwise go to SEND with the byte index at the first byte.
  - SEND: byte_valid=1 with byte_out = current byte. On byte_valid&&byte_ready, advance the index. When the last byte is accepted, deassert byte_valid the next cycle and go to GAP, or to NEXT if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES cycles with byte_valid=0, then go to NEXT.
  - NEXT: if counter==N_ENTRIES-1, pulse done=1 for one cycle, clear busy, go to IDLE. Otherwise increment counter and go to FETCH.
- Handshake rules:
  - byte_out is stable while byte_valid=1 and !byte_ready.
  - byte_valid never drops before acceptance.
  - At most one byte transfers per cycle; back-to-back transfers are allowed when byte_ready is held high.
- Latency: start to first byte_valid is 3 cycles (IDLE→FETCH→LOAD→SEND).
- Boundary conditions:
  - start while busy is ignored.
  - start coinciding with done starts no new run; start is sampled only in IDLE.
  - The counter never wraps within a run; rd_addr holds the last address after the run.
  - byte_ready while byte_valid=0 is ignored.
  - All-skipped memory completes in 3·N_ENTRIES+1 cycles with no byte traffic, then done.
  - Reset mid-transfer aborts immediately: byte_valid=0, busy=0, no done pulse.
  - Internal byte counters are 4-bit; the gap counter is sized by $clog2(GAP_CYCLES+1).

Test Plan:
- Entry 0 = class 3, opcode 0x21, coords 10 10 40 20, payload FF 00 00 …; other entries class 0; byte_ready=1 → bytes 21 10 10 40 20 FF 00 00, then a GAP_CYCLES idle gap, then done pulse, busy=0.
- Entry 0 = class 4, fill=1, opcode 0x22, coords 10 10 40 20, payload 11 22 33 44 55 66 → 13 bytes: 26 01 22 10 10 40 20 11 22 33 44 55 66. Repeat with fill=0 → second byte 00.
- Class 1 opcode 0x25 coords 00 00 5F 3F in entry 7, class 2 opcode 0x23 payload AB CD in entry 2 → 23 c0..c3 AB CD first, then 25 00 00 5F 3F; rd_addr sequence 0..7.
- byte_ready randomly toggled, including 5-cycle stalls mid-entry → byte_out/byte_valid stable during stalls; byte sequence identical to the no-stall run.
- All entries class 0 (word 96'h00_00_10_10_40_30_00_00_00_00_00_00) → no byte_valid; done 25 cycles after start (N_ENTRIES=8). start pulsed while busy → ignored.
- Assert rst during the 4th byte of a class-4 entry → byte_valid=0 and busy=0 asynchronously. A new start then restarts from rd_addr=0.
